// File: rtl/ch2_pkg.sv
// Shared constants for the channel-2 tick counter: 7-segment patterns
// (active-high, bit order gfedcba), BCD digit width and digit limits.
package ch2_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] DIGIT_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] DIGIT_ZERO = 4'd0;
  localparam logic [DIGIT_W-1:0] DIGIT_ONE  = 4'd1;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Digit to segment pattern; codes 10..15 never occur, blank them anyway.
  function automatic logic [6:0] seg_decode(input logic [DIGIT_W-1:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/ch2_sync.sv
// Single-bit synchronizer: STAGES flops in series, async active-low reset.
module ch2_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_chain <= '0;
    else          r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/ch2_tick_cnt.sv
// Channel-2 tick counter: synchronizes four ripple-divider taps, detects
// rising edges of the selected tap and counts them as two BCD digits with a
// sticky wrap flag.
// Optional: define CH2_TICK_SEG_EN to build the registered 7-segment decoder
// for the units digit; otherwise o_seg is tied blank.
module ch2_tick_cnt
  import ch2_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_q_in,
  input  logic [1:0] i_sel,
  input  logic       i_en,
  input  logic       i_clr,
  output logic       o_tick,
  output logic [7:0] o_bcd,
  output logic       o_ovf,
  output logic [6:0] o_seg
);

  logic [3:0]         w_sync;
  logic               w_cur;
  logic               w_sel_stable;
  logic               w_rise;
  logic [1:0]         r_sel_q;
  logic               r_prev;
  logic               r_tick;
  logic [DIGIT_W-1:0] r_units;
  logic [DIGIT_W-1:0] r_tens;
  logic               r_ovf;

  for (genvar g = 0; g < 4; g++) begin : g_sync
    ch2_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_q_in[g]),
      .o_q     (w_sync[g])
    );
  end

  assign w_cur        = w_sync[r_sel_q];
  assign w_sel_stable = (i_sel == r_sel_q);
  assign w_rise       = w_cur & ~r_prev & w_sel_stable;

  // Tap select, previous-tap and tick registers. The previous-tap register
  // follows the tap indexed by the incoming select, which equals the current
  // tap in steady state and preloads the new tap's level during a switch so
  // that a high new tap is not mistaken for an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel_q <= 2'd0;
      r_prev  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_sel_q <= i_sel;
      r_prev  <= w_sync[i_sel];
      r_tick  <= w_rise;
    end
  end

  // Two-digit BCD counter with sticky overflow; clear beats a tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_units <= DIGIT_ZERO;
      r_tens  <= DIGIT_ZERO;
      r_ovf   <= 1'b0;
    end else if (i_clr) begin
      r_units <= DIGIT_ZERO;
      r_tens  <= DIGIT_ZERO;
      r_ovf   <= 1'b0;
    end else if (r_tick && i_en) begin
      if (r_units == DIGIT_MAX) begin
        r_units <= DIGIT_ZERO;
        if (r_tens == DIGIT_MAX) begin
          r_tens <= DIGIT_ZERO;
          r_ovf  <= 1'b1;
        end else begin
          r_tens <= r_tens + DIGIT_ONE;
        end
      end else begin
        r_units <= r_units + DIGIT_ONE;
      end
    end
  end

  assign o_tick = r_tick;
  assign o_bcd  = {r_tens, r_units};
  assign o_ovf  = r_ovf;

`ifdef CH2_TICK_SEG_EN
  logic [6:0] r_seg;

  // Segment pattern trails the units digit by one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_seg <= SEG_0;
    else          r_seg <= seg_decode(r_units);
  end

  assign o_seg = r_seg;
`else
  assign o_seg = SEG_BLANK;
`endif

endmodule

// File: tb/tb_ch2_tick_cnt.sv
// Directed bench for ch2_tick_cnt with hand-computed expectations.
`timescale 1ns/1ps
module tb_ch2_tick_cnt;

  logic       clk;
  logic       rst_n;
  logic [3:0] q_in;
  logic [1:0] sel;
  logic       en;
  logic       clr;
  logic       tick;
  logic [7:0] bcd;
  logic       ovf;
  logic [6:0] seg;

  int n_checks = 0;
  int n_err    = 0;
  int tick_cnt = 0;
  int t0;

`ifdef CH2_TICK_SEG_EN
  localparam logic [6:0] EXP_SEG0 = 7'b0111111;
  localparam logic [6:0] EXP_SEG9 = 7'b1101111;
`else
  localparam logic [6:0] EXP_SEG0 = 7'b0000000;
  localparam logic [6:0] EXP_SEG9 = 7'b0000000;
`endif

  ch2_tick_cnt #(.SYNC_STAGES(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_q_in  (q_in),
    .i_sel   (sel),
    .i_en    (en),
    .i_clr   (clr),
    .o_tick  (tick),
    .o_bcd   (bcd),
    .o_ovf   (ovf),
    .o_seg   (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (tick === 1'b1) tick_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int idx, input int n);
    repeat (n) begin
      q_in[idx] = 1'b1;
      step(4);
      q_in[idx] = 1'b0;
      step(4);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q_in  = 4'd0;
    clr   = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    rst_n = 1'b0;
    q_in  = 4'd0;
    sel   = 2'd0;
    en    = 1'b1;
    clr   = 1'b0;
    #2;
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_bcd",  {24'd0, bcd},  32'h00);
    check("rst_ovf",  {31'd0, ovf},  32'd0);
    check("rst_seg",  {25'd0, seg},  {25'd0, EXP_SEG0});
    step(2);
    rst_n = 1'b1;
    step(1);

    // Basic latency and 8-cycle tap period.
    t0 = tick_cnt;
    q_in[0] = 1'b1;
    step(2);
    check("lat_pre",  {31'd0, tick}, 32'd0);
    step(1);
    check("lat_tick", {31'd0, tick}, 32'd1);
    step(1);
    check("lat_one",  {31'd0, tick}, 32'd0);
    check("bcd_01",   {24'd0, bcd},  32'h01);
    q_in[0] = 1'b0;
    step(4);
    q_in[0] = 1'b1;
    step(3);
    check("tick2",    {31'd0, tick}, 32'd1);
    step(1);
    check("bcd_02",   {24'd0, bcd},  32'h02);
    q_in[0] = 1'b0;
    step(4);
    check("ticks_2",  tick_cnt - t0, 32'd2);

    // Full range, wrap, sticky overflow and clear.
    do_reset();
    t0 = tick_cnt;
    pulse(0, 99);
    check("bcd_99",   {24'd0, bcd},  32'h99);
    check("ovf_99",   {31'd0, ovf},  32'd0);
    pulse(0, 1);
    check("bcd_wrap", {24'd0, bcd},  32'h00);
    check("ovf_wrap", {31'd0, ovf},  32'd1);
    check("ticks_100", tick_cnt - t0, 32'd100);
    pulse(0, 2);
    check("ovf_stick", {31'd0, ovf}, 32'd1);
    check("bcd_02w",  {24'd0, bcd},  32'h02);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_bcd",  {24'd0, bcd},  32'h00);
    check("clr_ovf",  {31'd0, ovf},  32'd0);

    // Units carry into tens, segment follows one cycle later.
    do_reset();
    pulse(0, 9);
    check("bcd_09",   {24'd0, bcd},  32'h09);
    check("seg_9",    {25'd0, seg},  {25'd0, EXP_SEG9});
    q_in[0] = 1'b1;
    step(4);
    check("bcd_10",   {24'd0, bcd},  32'h10);
    check("seg_lag",  {25'd0, seg},  {25'd0, EXP_SEG9});
    step(1);
    check("seg_0",    {25'd0, seg},  {25'd0, EXP_SEG0});
    q_in[0] = 1'b0;
    step(3);

    // Tap switch onto a high tap gives no tick; its next rise gives one.
    q_in[3] = 1'b1;
    step(4);
    t0 = tick_cnt;
    sel = 2'd3;
    step(6);
    check("sw_notick", tick_cnt - t0, 32'd0);
    check("sw_bcd",   {24'd0, bcd},  32'h10);
    q_in[3] = 1'b0;
    step(4);
    q_in[3] = 1'b1;
    step(4);
    check("sw_tick",  tick_cnt - t0, 32'd1);
    check("sw_bcd11", {24'd0, bcd},  32'h11);
    q_in[3] = 1'b0;
    step(4);
    sel = 2'd0;
    step(4);

    // Clear wins over a simultaneous tick; disabled count still ticks.
    do_reset();
    pulse(0, 42);
    check("bcd_42",   {24'd0, bcd},  32'h42);
    q_in[0] = 1'b1;
    step(3);
    check("clr_tick", {31'd0, tick}, 32'd1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_prio", {24'd0, bcd},  32'h00);
    q_in[0] = 1'b0;
    step(4);
    pulse(0, 3);
    en = 1'b0;
    t0 = tick_cnt;
    pulse(0, 5);
    check("en0_ticks", tick_cnt - t0, 32'd5);
    check("en0_bcd",  {24'd0, bcd},  32'h03);
    en = 1'b1;
    step(2);

    // Asynchronous reset mid-count discards an in-flight edge.
    do_reset();
    pulse(0, 157);
    check("bcd_57",   {24'd0, bcd},  32'h57);
    check("ovf_57",   {31'd0, ovf},  32'd1);
    q_in[0] = 1'b1;
    step(1);
    rst_n = 1'b0;
    q_in[0] = 1'b0;
    #1;
    check("arst_bcd",  {24'd0, bcd},  32'h00);
    check("arst_ovf",  {31'd0, ovf},  32'd0);
    check("arst_tick", {31'd0, tick}, 32'd0);
    check("arst_seg",  {25'd0, seg},  {25'd0, EXP_SEG0});
    step(1);
    rst_n = 1'b1;
    t0 = tick_cnt;
    step(6);
    check("arst_quiet", tick_cnt - t0, 32'd0);
    pulse(0, 1);
    check("arst_fresh", tick_cnt - t0, 32'd1);
    check("arst_bcd1", {24'd0, bcd},  32'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ch2_tick_cnt.md
CH2_TICK_CNT -- requirements
Module: ch2_tick_cnt

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchronizer flops per Q_IN bit; legal range 2..4.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 Q_IN  input  4  ripple-divider taps (CLK/2, /4, /8, /16), asynchronous to CLK.
REQ-005 SEL  input  2  tap select; value n selects Q_IN[n].
REQ-006 EN  input  1  count enable.
REQ-007 CLR  input  1  synchronous clear of count and overflow.
REQ-008 TICK  output  1  one-cycle pulse per rising edge of the selected tap.
REQ-009 BCD  output  8  two-digit BCD count; [7:4] tens, [3:0] units, range 00..99.
REQ-010 OVF  output  1  sticky wrap flag.
REQ-011 SEG  output  7  units-digit 7-segment pattern, active-high, bit order gfedcba.

Function
REQ-012 Each Q_IN bit SHALL pass through its own SYNC_STAGES-deep flop chain before any other use.
REQ-013 SEL SHALL be registered (SEL_Q); the synchronized bit indexed by SEL_Q is the current tap.
REQ-014 A previous-tap register SHALL load the current tap every cycle.
REQ-015 TICK SHALL be 1 for exactly one cycle when current tap = 1 and previous tap = 0.
REQ-016 Latency: rising edge of selected Q_IN bit to TICK high SHALL be SYNC_STAGES+1 CLK cycles, sampling uncertainty of ±1 cycle included.
REQ-017 In any cycle where SEL differs from SEL_Q, TICK SHALL be forced 0; previous-tap still updates, so a tap switch never produces a spurious tick.
REQ-018 TICK SHALL pulse regardless of EN.
REQ-019 On TICK=1 and EN=1 and CLR=0: units +1; units 9 -> 0 with tens +1.
REQ-020 BCD 99 with an increment SHALL wrap to 00 and set OVF=1 in the same cycle.
REQ-021 OVF SHALL stay 1 until CLR or reset; further wraps keep it 1.
REQ-022 CLR=1 SHALL set BCD=00 and OVF=0 next cycle and SHALL take priority over a simultaneous TICK.
REQ-023 EN=0 SHALL hold BCD and OVF unchanged.
REQ-024 BCD digits SHALL never hold values 10..15.
REQ-025 SEG SHALL be registered from the units digit, one cycle after BCD updates; patterns 0..9 are the standard active-high set (0=0111111, 1=0000110, 9=1101111).

Reset
REQ-026 On RST_N=0, immediately: all synchronizer flops, SEL_Q, previous-tap register, TICK, BCD, OVF = 0.
REQ-027 On RST_N=0, SEG SHALL be 0111111 (digit 0) when CH2_TICK_SEG_EN is defined, else 0000000.
REQ-028 Reset asserted mid-count SHALL discard any in-flight edge; first TICK after release requires a new 0->1 on the selected tap after SYNC_STAGES+1 cycles.
REQ-029 Reset release SHALL be synchronous to CLK by the integration; the block adds no reset synchronizer.

Configuration
REQ-030 Macro CH2_TICK_SEG_EN: defined -> 7-segment decoder and SEG register compiled in per REQ-025.
REQ-031 Macro CH2_TICK_SEG_EN undefined -> no decoder logic; SEG tied to 0000000; all other behaviour identical.

Structure
REQ-032 Shared package ch2_pkg SHALL hold: the 10 segment-pattern constants, SEG_BLANK constant, BCD digit width constant (4), max digit constant (9).
REQ-033 One sub-module ch2_sync SHALL implement a single-bit SYNC_STAGES flop chain with async active-low reset; instantiated 4 times.
REQ-034 Tap mux, edge detect, BCD counter and SEG decode SHALL live in ch2_tick_cnt.

Verification
REQ-035 Reset, SEL=0, EN=1, Q_IN[0] toggling every 4 CLK -> one TICK per 8 CLK, first TICK 3 cycles after first rise, BCD 00->01->02.
REQ-036 EN=1, 100 selected-tap rises from reset -> BCD 99 after 99 ticks, 00 with OVF=1 after tick 100; CLR pulse -> BCD 00, OVF 0.
REQ-037 BCD=09 plus one tick -> BCD=10; SEG goes 1101111 -> 0111111 one cycle later (macro defined); SEG stays 0000000 (macro undefined).
REQ-038 SEL switched 0->3 while Q_IN[0]=0, Q_IN[3]=1 -> no TICK; next Q_IN[3] rise -> one TICK.
REQ-039 CLR and TICK in same cycle at BCD=42 -> BCD=00; EN=0 with 5 tap rises -> 5 TICKs, BCD unchanged.
REQ-040 RST_N low for 1 cycle at BCD=57, OVF=1 -> BCD=00, OVF=0, TICK=0 immediately, no TICK until next fresh rise.
